// File: rtl/rf_scoreboard_pkg.sv
// Shared constants and types for the register-file write scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   REG_X0      index of the hard-wired zero register (never tracked)
//   SB_CNT_W    default width of each per-register pending-write counter
//   NUM_REGS    architectural integer register count
//   OUTST_W     width of the total-outstanding counter output
//   iss_req_t   bundle of the ID-stage issue request fields
//   is_tracked  true for any register index whose writes are tracked
package rf_scoreboard_pkg;

    localparam int          REG_IDX_W = 5;
    localparam int          NUM_REGS  = 32;
    localparam int          SB_CNT_W  = 2;
    localparam int          OUTST_W   = 7;
    localparam logic [4:0]  REG_X0    = 5'd0;

    // Issue-side request as presented by the ID stage.
    typedef struct packed {
        logic [REG_IDX_W-1:0] rs1;
        logic                 rs1_use;
        logic [REG_IDX_W-1:0] rs2;
        logic                 rs2_use;
        logic [REG_IDX_W-1:0] rd;
        logic                 rf_we;
    } iss_req_t;

    // x0 is hard-wired; writes to it never become pending.
    function automatic logic is_tracked(input logic [REG_IDX_W-1:0] idx);
        return idx != REG_X0;
    endfunction

endpackage : rf_scoreboard_pkg

// File: rtl/rf_scoreboard_sb_counter.sv
// Saturating up/down counter tracking in-flight writes for one register.
// Latency: count updates one clock after inc/dec/clr; flags reflect registered count.
// Backpressure: none; caller must not request inc when full (dec at zero is ignored).
//
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset, clears the count
//   clr_i     synchronous clear (flush), beats inc/dec
//   inc_i     add one pending write
//   dec_i     retire one pending write
//   zero_o    registered count is zero
//   full_o    registered count is at its maximum
//   nz_nxt_o  next-state count is nonzero (lets the parent register busy in step)
module sb_counter
    import rf_scoreboard_pkg::*;
#(
    parameter int W = SB_CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic full_o,
    output logic nz_nxt_o
);

    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign zero_o = (cnt_q == '0);
    assign full_o = (cnt_q == CNT_MAX);

    // inc and dec together cancel; each direction saturates rather than wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && !full_o) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (dec_i && !inc_i && !zero_o) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    assign nz_nxt_o = (cnt_d != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : sb_counter

// File: rtl/rf_scoreboard.sv
// Register-file write scoreboard: tracks pending writes per register, stalls RAW/overflow issues.
// Latency: stall/iss_ack combinational from registered state; busy/outstanding/sb_err update next edge.
// Backpressure: stall holds the ID stage; retires are never back-pressured.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               discard every pending write (issue/retire that cycle ignored)
//   iss_valid           ID presents an instruction
//   iss_rs1/2, _use     source indices and whether each is read
//   iss_rd, iss_rf_we   destination index and write enable
//   wb_valid, wb_rd     one RF write retiring this cycle
//   stall, iss_ack      hold / accept indication to ID
//   busy[31:0]          per-register pending flag (registered)
//   outstanding[6:0]    total pending writes (registered)
//   sb_err              sticky: a retire hit a register with nothing pending
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 iss_valid,
    input  logic [4:0]           iss_rs1,
    input  logic [4:0]           iss_rs2,
    input  logic                 iss_rs1_use,
    input  logic                 iss_rs2_use,
    input  logic [4:0]           iss_rd,
    input  logic                 iss_rf_we,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,
    output logic                 stall,
    output logic                 iss_ack,
    output logic [NUM_REGS-1:0]  busy,
    output logic [OUTST_W-1:0]   outstanding,
    output logic                 sb_err
);

    iss_req_t            iss_req;

    logic [NUM_REGS-1:0] zero_vec;
    logic [NUM_REGS-1:0] full_vec;
    logic [NUM_REGS-1:0] nz_nxt_vec;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [OUTST_W-1:0]  outstanding_q;
    logic [OUTST_W-1:0]  outstanding_d;
    logic                sb_err_q;
    logic                sb_err_d;

    logic                raw_hazard;
    logic                cnt_overflow;
    logic                do_inc;
    logic                wb_hit;
    logic                do_dec;
    logic                wb_orphan;

    assign iss_req.rs1     = iss_rs1;
    assign iss_req.rs1_use = iss_rs1_use;
    assign iss_req.rs2     = iss_rs2;
    assign iss_req.rs2_use = iss_rs2_use;
    assign iss_req.rd      = iss_rd;
    assign iss_req.rf_we   = iss_rf_we;

    // Hazards look only at registered busy/full: a retire in the same cycle does
    // not release a reader, which keeps stall off the writeback timing path.
    // busy_q[0] and full_vec[0] are constant 0, so x0 never stalls.
    assign raw_hazard   = (iss_req.rs1_use && busy_q[iss_req.rs1]) ||
                          (iss_req.rs2_use && busy_q[iss_req.rs2]);
    assign cnt_overflow = iss_req.rf_we && is_tracked(iss_req.rd) && full_vec[iss_req.rd];

    assign stall   = iss_valid && (raw_hazard || cnt_overflow);
    assign iss_ack = iss_valid && !stall;

    // Flush suppresses issue/retire side effects but not the handshake itself.
    assign do_inc    = iss_ack && iss_req.rf_we && is_tracked(iss_req.rd) && !flush;
    assign wb_hit    = wb_valid && is_tracked(wb_rd) && !flush;
    assign do_dec    = wb_hit && !zero_vec[wb_rd];
    assign wb_orphan = wb_hit && zero_vec[wb_rd];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == 0) begin : g_x0
            assign zero_vec[i]   = 1'b1;
            assign full_vec[i]   = 1'b0;
            assign nz_nxt_vec[i] = 1'b0;
        end else begin : g_cnt
            sb_counter #(
                .W        (CNT_W)
            ) u_cnt (
                .clk_i    (clk),
                .rst_i    (rst),
                .clr_i    (flush),
                .inc_i    (do_inc && (iss_req.rd == 5'(i))),
                .dec_i    (do_dec && (wb_rd == 5'(i))),
                .zero_o   (zero_vec[i]),
                .full_o   (full_vec[i]),
                .nz_nxt_o (nz_nxt_vec[i])
            );
        end
    end

    // At most one increment and one decrement per cycle, so the running total
    // moves by -1/0/+1; an issue and retire to the same register net to zero
    // here exactly as they do inside that register's counter.
    always_comb begin
        busy_d        = nz_nxt_vec;
        outstanding_d = outstanding_q;
        sb_err_d      = sb_err_q || wb_orphan;
        if (flush) begin
            outstanding_d = '0;
        end else begin
            outstanding_d = outstanding_q + {{(OUTST_W-1){1'b0}}, do_inc}
                                          - {{(OUTST_W-1){1'b0}}, do_dec};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            sb_err_q      <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            sb_err_q      <= sb_err_d;
        end
    end

    assign busy        = busy_q;
    assign outstanding = outstanding_q;
    assign sb_err      = sb_err_q;

endmodule : rf_scoreboard

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed scenarios then a randomized run.
// Latency: checks stall/iss_ack mid-cycle and registered outputs 1ns after each edge.
// Backpressure: stalled issues are simply not counted by the reference model.
module tb_rf_scoreboard;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst, flush, iss_valid, iss_rs1_use, iss_rs2_use, iss_rf_we, wb_valid;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd, wb_rd;
    logic        stall, iss_ack, sb_err;
    logic [31:0] busy;
    logic [6:0]  outstanding;

    int          errors = 0;
    int          checks = 0;

    // Reference model: plain per-register pending counts plus a sticky error bit.
    int          mcnt [32];
    bit          merr;
    logic        last_stall, last_ack;

    always #5 clk = ~clk;

    rf_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .iss_valid   (iss_valid),
        .iss_rs1     (iss_rs1),
        .iss_rs2     (iss_rs2),
        .iss_rs1_use (iss_rs1_use),
        .iss_rs2_use (iss_rs2_use),
        .iss_rd      (iss_rd),
        .iss_rf_we   (iss_rf_we),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .stall       (stall),
        .iss_ack     (iss_ack),
        .busy        (busy),
        .outstanding (outstanding),
        .sb_err      (sb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = (mcnt[i] != 0);
        return b;
    endfunction

    function automatic int model_sum();
        int s = 0;
        for (int i = 0; i < 32; i++) s += mcnt[i];
        return s;
    endfunction

    // One clock of stimulus: apply inputs, check the handshake against the model,
    // advance the model at the edge, then check the registered outputs.
    task automatic cyc(input bit r, input bit f, input bit v,
                       input logic [4:0] rs1, input bit u1,
                       input logic [4:0] rs2, input bit u2,
                       input logic [4:0] rd,  input bit we,
                       input bit wv, input logic [4:0] wrd);
        bit e_stall, e_ack;
        int pre_wb;
        rst = r; flush = f; iss_valid = v;
        iss_rs1 = rs1; iss_rs1_use = u1; iss_rs2 = rs2; iss_rs2_use = u2;
        iss_rd = rd; iss_rf_we = we; wb_valid = wv; wb_rd = wrd;
        #1;
        e_stall = v && ((u1 && mcnt[rs1] != 0) || (u2 && mcnt[rs2] != 0) ||
                        (we && rd != 0 && mcnt[rd] == MAXC));
        e_ack   = v && !e_stall;
        last_stall = stall;
        last_ack   = iss_ack;
        chk("stall", {31'b0, stall}, {31'b0, e_stall});
        chk("iss_ack", {31'b0, iss_ack}, {31'b0, e_ack});
        @(posedge clk);
        if (r) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            merr = 0;
        end else if (f) begin
            foreach (mcnt[i]) mcnt[i] = 0;
        end else begin
            pre_wb = mcnt[wrd];
            if (e_ack && we && rd != 0) mcnt[rd]++;
            if (wv && wrd != 0) begin
                if (pre_wb > 0) mcnt[wrd]--;
                else merr = 1;
            end
        end
        #1;
        chk("busy", busy, model_busy());
        chk("outstanding", {25'b0, outstanding}, model_sum());
        chk("sb_err", {31'b0, sb_err}, {31'b0, merr});
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int pend [$];
        logic [4:0] r1, r2, rdv, wrv;
        bit v, u1, u2, we, wv, fl;

        foreach (mcnt[i]) mcnt[i] = 0;
        merr = 0;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_outst", {25'b0, outstanding}, 32'd0);
        chk("rst_err", {31'b0, sb_err}, 32'd0);

        // Issue rd=5, then a reader of x5 must stall
        cyc(0, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        chk("i5_busy5", {31'b0, busy[5]}, 32'd1);
        chk("i5_outst", {25'b0, outstanding}, 32'd1);
        cyc(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        chk("raw_stall", {31'b0, last_stall}, 32'd1);
        chk("raw_ack", {31'b0, last_ack}, 32'd0);

        // Retire x5 with a same-cycle reader: no bypass, stall that cycle only
        cyc(0, 0, 1, 5, 1, 0, 0, 0, 0, 1, 5);
        chk("wb_nobypass", {31'b0, last_stall}, 32'd1);
        chk("wb_busy5", {31'b0, busy[5]}, 32'd0);
        chk("wb_stall_clr", {31'b0, stall}, 32'd0);

        // Saturation on x7, then same-cycle issue+retire keeps count
        repeat (3) cyc(0, 0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        chk("sat_outst3", {25'b0, outstanding}, 32'd3);
        cyc(0, 0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        chk("sat_stall", {31'b0, last_stall}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        chk("sat_dec", {25'b0, outstanding}, 32'd2);
        cyc(0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 7);
        chk("same_ack", {31'b0, last_ack}, 32'd1);
        chk("same_hold", {25'b0, outstanding}, 32'd2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        chk("sat_drain", busy, 32'h0);

        // x0 is ignored; retire to an idle register sets sticky error
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("x0_busy", busy, 32'h0);
        chk("x0_err", {31'b0, sb_err}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        chk("orphan_err", {31'b0, sb_err}, 32'd1);
        idle();
        idle();
        chk("err_sticky", {31'b0, sb_err}, 32'd1);

        // Flush with five pending and a simultaneous issue
        cyc(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 2, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 4, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 6, 1, 0, 0);
        chk("pre_flush", {25'b0, outstanding}, 32'd5);
        cyc(0, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
        chk("flush_ack", {31'b0, last_ack}, 32'd1);
        chk("flush_busy", busy, 32'h0);
        chk("flush_outst", {25'b0, outstanding}, 32'd0);
        chk("flush_err", {31'b0, sb_err}, 32'd1);

        // Reset overrides flush and retire; first cycle after reset never stalls
        cyc(0, 0, 1, 0, 0, 0, 0, 4, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        chk("rst_mid_busy", busy, 32'h0);
        chk("rst_mid_outst", {25'b0, outstanding}, 32'd0);
        chk("rst_mid_err", {31'b0, sb_err}, 32'd0);
        cyc(0, 0, 1, 4, 1, 4, 1, 4, 1, 0, 0);
        chk("post_rst_stall", {31'b0, last_stall}, 32'd0);

        // Randomized run against the reference model
        for (int n = 0; n < 600; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            u1  = 1'($urandom_range(0, 1));
            u2  = 1'($urandom_range(0, 1));
            rdv = 5'($urandom_range(0, 7));
            we  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            pend.delete();
            for (int i = 1; i < 32; i++) if (mcnt[i] != 0) pend.push_back(i);
            wv  = 0;
            wrv = 0;
            if (pend.size() != 0 && $urandom_range(0, 2) != 0) begin
                wv  = 1;
                wrv = 5'(pend[$urandom_range(0, pend.size() - 1)]);
            end else if ($urandom_range(0, 9) == 0) begin
                wv  = 1;
                wrv = 0;
            end
            cyc(0, fl, v, r1, u1, r2, u2, rdv, we, wv, wrv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rf_scoreboard
